// File: rtl/brew_bus_pad_ctrl_if.sv
// Bus bundle for brew_bus_pad_ctrl: core-side strobes, DRAM pad drives,
// external-master request/grant and the asynchronous DRQ/nINT inputs.
interface brew_bus_pad_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int DMA_CH = 4
);
    localparam int LANES = DATA_W / 8;

    logic              core_nRAS;
    logic              core_nWE;
    logic [LANES-1:0]  core_nCAS;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_data_out;
    logic              core_data_out_en;
    logic              core_idle;
    logic              core_bus_gnt;
    logic              pad_nRAS;
    logic              pad_nWE;
    logic [LANES-1:0]  pad_nCAS;
    logic [ADDR_W-1:0] pad_addr;
    logic [DATA_W-1:0] pad_data_out;
    logic              pad_ctrl_oe;
    logic              pad_data_oe;
    logic              ext_nBREQ;
    logic              ext_nBGNT;
    logic [DMA_CH-1:0] drq;
    logic [DMA_CH-1:0] drq_sync;
    logic              nINT;
    logic              int_sync;

    modport master (
        output core_nRAS, core_nWE, core_nCAS, core_addr, core_data_out,
               core_data_out_en, core_idle, ext_nBREQ, drq, nINT,
        input  core_bus_gnt, pad_nRAS, pad_nWE, pad_nCAS, pad_addr,
               pad_data_out, pad_ctrl_oe, pad_data_oe, ext_nBGNT,
               drq_sync, int_sync
    );

    modport slave (
        input  core_nRAS, core_nWE, core_nCAS, core_addr, core_data_out,
               core_data_out_en, core_idle, ext_nBREQ, drq, nINT,
        output core_bus_gnt, pad_nRAS, pad_nWE, pad_nCAS, pad_addr,
               pad_data_out, pad_ctrl_oe, pad_data_oe, ext_nBGNT,
               drq_sync, int_sync
    );
endinterface

// File: rtl/brew_bus_pad_ctrl.sv
// DRAM pad driver and bus-ownership controller: hands the bus to an external
// master via a release cycle plus tristate turnaround, and synchronises DRQ/nINT.
module brew_bus_pad_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 11,
    parameter int DMA_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    brew_bus_pad_ctrl_if.slave    bus
);
    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = $clog2(TURNAROUND + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURNAROUND - 1);

    typedef enum logic [2:0] {
        S_TURN_IN,
        S_CORE,
        S_RELEASE,
        S_TURN_OUT,
        S_EXT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Request chain holds the inverted (active-high) request so that a
    // cleared synchroniser reads as "no request".
    logic [SYNC_STAGES-1:0] r_breq_sync;
    logic [SYNC_STAGES-1:0] r_int_sync;
    logic [DMA_CH-1:0]      r_drq_sync [SYNC_STAGES];
    logic                   w_breq;

    logic              w_gnt;
    logic              w_ctrl_oe;
    logic              w_data_oe;
    logic              w_nbgnt;
    logic              w_force_idle;
    logic [ADDR_W-1:0] w_addr;

    assign w_breq = r_breq_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_breq_sync <= '0;
            r_int_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_drq_sync[i] <= '0;
            end
        end else begin
            r_breq_sync   <= {r_breq_sync[SYNC_STAGES-2:0], ~bus.ext_nBREQ};
            r_int_sync    <= {r_int_sync[SYNC_STAGES-2:0], ~bus.nINT};
            r_drq_sync[0] <= bus.drq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_drq_sync[i] <= r_drq_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_TURN_IN;
            r_cnt   <= CNT_LOAD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The turnaround counter reloads on entry to either Z phase and exits at zero.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_gnt        = 1'b0;
        w_ctrl_oe    = 1'b0;
        w_data_oe    = 1'b0;
        w_nbgnt      = 1'b1;
        w_force_idle = 1'b0;
        case (r_state)
            S_TURN_IN: begin
                if (r_cnt == '0) w_state_nxt = S_CORE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            S_CORE: begin
                w_gnt     = 1'b1;
                w_ctrl_oe = 1'b1;
                w_data_oe = bus.core_data_out_en;
                if (w_breq && bus.core_idle) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                w_ctrl_oe    = 1'b1;
                w_force_idle = 1'b1;
                w_state_nxt  = S_TURN_OUT;
                w_cnt_nxt    = CNT_LOAD;
            end
            S_TURN_OUT: begin
                if (r_cnt == '0) w_state_nxt = S_EXT;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            S_EXT: begin
                w_nbgnt = 1'b0;
                if (!w_breq) begin
                    w_state_nxt = S_TURN_IN;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_TURN_IN;
                w_cnt_nxt   = CNT_LOAD;
            end
        endcase
    end

    assign w_addr           = bus.core_addr;
    assign bus.core_bus_gnt = w_gnt;
    assign bus.pad_ctrl_oe  = w_ctrl_oe;
    assign bus.pad_data_oe  = w_data_oe;
    assign bus.ext_nBGNT    = w_nbgnt;
    assign bus.pad_nRAS     = w_force_idle ? 1'b1 : bus.core_nRAS;
    assign bus.pad_nWE      = w_force_idle ? 1'b1 : bus.core_nWE;
    assign bus.pad_nCAS     = w_force_idle ? {LANES{1'b1}} : bus.core_nCAS;
    assign bus.pad_addr     = w_addr;
    assign bus.pad_data_out = bus.core_data_out;
    assign bus.drq_sync     = r_drq_sync[SYNC_STAGES-1];
    assign bus.int_sync     = r_int_sync[SYNC_STAGES-1];
endmodule
